vram_write_queue: RTL
=====================

Name: vram_write_queue

Overview:
Upstream feeder for the GPU's tile, attribute and colour memories. It takes 6502 bus register writes and re-times them into the clk domain. It also keeps an auto-incrementing VRAM pointer and queues the writes in a small FIFO. It drains that FIFO as single-cycle write strobes on the memory write ports, optionally only during blanking so pixel fetch never contends.

Parameters:
FIFO_DEPTH, 8, queue entries (power of two, >=2)
BLANK_ONLY, 0, 1 = pop only while vga_blank is high; 0 = pop whenever non-empty
SYNC_STAGES, 2, flip-flop stages on cpu_clk/cs/rw (>=2)

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  reset
cpu_clk  input  1  6502 phi2, asynchronous to clk
cs  input  1  chip select, active high
rw  input  1  1 = read, 0 = write
addr  input  3  register select
data  input  8  CPU write data
vga_blank  input  1  blanking from the sync generator (clk domain)
tile_memory_write_enable  output  1  one-cycle strobe
attribute_memory_write_enable  output  1  one-cycle strobe
color_memory_write_enable  output  1  one-cycle strobe
memory_write_addr  output  12  shared write address; tile uses [10:0], colour uses [3:0]
memory_write_data  output  8  shared write data
fifo_level  output  log2(FIFO_DEPTH)+1  current occupancy
overflow  output  1  sticky; set when a push is dropped

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low. While rst=0, every register clears:
  - ptr=0, step=1, target=0, FIFO empty, overflow=0.
  - All enables=0; memory_write_addr=0; memory_write_data=0.
  - All sync flops=0, so no false cpu_clk falling edge is seen after reset.
- Synchronisation: cpu_clk, cs and rw pass through SYNC_STAGES flops.
- Bus capture: on each clk edge where synced cpu_clk=1, capture {cs, rw, addr, data} into bus holding registers.
- Commit:
  - A falling edge of synced cpu_clk is detected by comparison against one extra delay flop.
  - On that edge, if held cs=1 and rw=0, commit a register write from the held values.
  - Commit occurs SYNC_STAGES+1 clk cycles after the cpu_clk pin falls.
  - Reads (rw=1) have no effect.
- Register map (addr):
  - 0: ptr[7:0] = data.
  - 1: ptr[11:8] = data[3:0]; target = data[5:4] (00 tile, 01 attribute, 10 colour, 11 discard); data[7:6] ignored.
  - 2: push {target, ptr, data}; then ptr = (ptr + step) mod 4096. ptr advances even when the push is dropped.
  - 3: step = data (0 allowed = fixed address).
  - 4: clear overflow (data ignored).
  - 5-7: ignored.
- Pop rule: pop when FIFO non-empty and (BLANK_ONLY=0 or vga_blank=1); at most one entry per clk.
- Pop output timing:
  - The cycle after a pop, exactly one enable matching the entry's target is high for one cycle.
  - memory_write_addr and memory_write_data carry the entry in that same cycle.
  - For target 11, no enable is raised; the entry is consumed silently.
  - Enables are registered and never high two cycles in a row for a single entry.
  - memory_write_addr and memory_write_data hold their last value when idle.
- Full FIFO:
  - A push while full with no pop in the same cycle is dropped and sets overflow=1.
  - A push while full with a pop in the same cycle is accepted; the level stays at FIFO_DEPTH.
- Empty FIFO: no pop occurs and all enables are 0.
- Simultaneous overflow set and clear: a register-4 clear and an overflow set cannot coincide, since one commit per CPU cycle.
- Ordering: FIFO is strictly first-in first-out; pointers wrap modulo FIFO_DEPTH.
- fifo_level updates the same cycle as the push or pop.
- Reset mid-drain: queued entries are lost; an asserted enable drops to 0 immediately (asynchronous).

Test Plan:
- Sequential fill:
  - Stimulus: write reg1=0x00, reg0=0x10, reg3=1, then reg2=0xAA and reg2=0xBB; BLANK_ONLY=0.
  - Response: tile strobe with addr 0x010/data 0xAA, then tile strobe with addr 0x011/data 0xBB. Each strobe is one cycle, SYNC_STAGES+2 clk after its cpu_clk fall. Final ptr=0x012.
- Pointer wrap and colour target:
  - Stimulus: reg1=0x2F (target colour, ptr[11:8]=F), reg0=0xFF, reg3=2, then two reg2 writes.
  - Response: colour strobes at addr 0xFFF then 0x001.
- Blank gating:
  - Stimulus: BLANK_ONLY=1, vga_blank=0, push 3 entries.
  - Response: fifo_level=3 and no strobes. Raise vga_blank: 3 strobes on consecutive-cycle pops, fifo_level reaches 0.
- Overflow:
  - Stimulus: BLANK_ONLY=1, vga_blank=0, FIFO_DEPTH=8, push 9 entries.
  - Response: fifo_level=8, overflow=1, ninth entry absent on drain, ptr advanced by 9 steps. A reg4 write clears overflow.
- Discard target and reads:
  - Stimulus: target=11 pushes, plus rw=1 cycles with cs=1.
  - Response: no enables, FIFO empties; reads leave ptr/step/FIFO unchanged.
- Reset mid-operation:
  - Stimulus: assert rst=0 with 4 entries queued and an enable high.
  - Response: enable drops immediately, fifo_level=0, ptr=0, step=1. First cpu_clk cycle after release produces no commit unless cs=1 and rw=0.

Source files
------------

// File: rtl/vram_write_queue.sv
// -----------------------------------------------------------------------------
// vram_write_queue
//
// Takes 6502 register writes from the asynchronous phi2 domain and re-times
// them into clk. It keeps an auto-incrementing 12-bit VRAM pointer. Data
// writes are queued in a small FIFO, which drains as single-cycle write
// strobes to the tile, attribute or colour memory. When BLANK_ONLY is set,
// the FIFO drains only while vga_blank is high, so that pixel fetch never
// contends with the writes.
//
// Register map (addr, committed on the falling edge of phi2 with cs=1, rw=0):
//   0 : ptr[7:0]  = data
//   1 : ptr[11:8] = data[3:0], target = data[5:4]
//       (00 tile, 01 attribute, 10 colour, 11 discard)
//   2 : push {target, ptr, data}, then ptr += step (mod 4096)
//   3 : step = data
//   4 : clear sticky overflow
//   5-7 : no effect
//
// Ports:
//   clk, rst                       system clock, async active-low reset
//   cpu_clk, cs, rw, addr, data    6502 bus (cpu_clk/cs/rw asynchronous)
//   vga_blank                      blanking indicator, clk domain
//   *_memory_write_enable          one-cycle write strobes, registered
//   memory_write_addr/_data        shared write address/data; these hold
//                                  their value when no strobe is issued
//   fifo_level                     current queue occupancy
//   overflow                       sticky flag, set when a push is dropped
// -----------------------------------------------------------------------------
module vram_write_queue #(
    parameter int FIFO_DEPTH  = 8,
    parameter int BLANK_ONLY  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_clk,
    input  logic                          cs,
    input  logic                          rw,
    input  logic [2:0]                    addr,
    input  logic [7:0]                    data,
    input  logic                          vga_blank,
    output logic                          tile_memory_write_enable,
    output logic                          attribute_memory_write_enable,
    output logic                          color_memory_write_enable,
    output logic [11:0]                   memory_write_addr,
    output logic [7:0]                    memory_write_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        TGT_TILE    = 2'b00,
        TGT_ATTR    = 2'b01,
        TGT_COLOR   = 2'b10,
        TGT_DISCARD = 2'b11
    } target_t;

    typedef struct packed {
        target_t     target;
        logic [11:0] addr;
        logic [7:0]  data;
    } entry_t;

    // ------------------------------------------------------------------
    // Bus synchronisation and capture
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] cpu_clk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] rw_sync;
    logic                   cpu_clk_s;
    logic                   cs_s;
    logic                   rw_s;
    logic                   cpu_clk_d;

    logic                   held_cs;
    logic                   held_rw;
    logic [2:0]             held_addr;
    logic [7:0]             held_data;

    assign cpu_clk_s = cpu_clk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign rw_s      = rw_sync[SYNC_STAGES-1];

    // addr and data are sampled raw. They are only used while the synced
    // phi2 is high, so the CPU has already been driving them for
    // SYNC_STAGES cycles by the time they are captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_clk_sync <= '0;
            cs_sync      <= '0;
            rw_sync      <= '0;
            cpu_clk_d    <= 1'b0;
            held_cs      <= 1'b0;
            held_rw      <= 1'b0;
            held_addr    <= '0;
            held_data    <= '0;
        end else begin
            cpu_clk_sync <= {cpu_clk_sync[SYNC_STAGES-2:0], cpu_clk};
            cs_sync      <= {cs_sync[SYNC_STAGES-2:0], cs};
            rw_sync      <= {rw_sync[SYNC_STAGES-2:0], rw};
            cpu_clk_d    <= cpu_clk_s;
            if (cpu_clk_s) begin
                held_cs   <= cs_s;
                held_rw   <= rw_s;
                held_addr <= addr;
                held_data <= data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit decode and FIFO handshake
    // ------------------------------------------------------------------
    logic        cpu_fall;
    logic        commit;
    logic        do_push;
    logic        do_clear;
    logic        do_pop;
    logic        accept;
    logic        fifo_empty;
    logic        fifo_full;

    logic [11:0] ptr;
    logic [7:0]  step;
    target_t     target;

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [CW-1:0] count;
    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    entry_t        new_entry;

    assign cpu_fall   = cpu_clk_d & ~cpu_clk_s;
    assign commit     = cpu_fall & held_cs & ~held_rw;
    assign do_push    = commit && (held_addr == 3'd2);
    assign do_clear   = commit && (held_addr == 3'd4);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);
    assign do_pop     = !fifo_empty && ((BLANK_ONLY == 0) || vga_blank);
    // A full queue can still accept a push when an entry leaves on the
    // same edge; the incoming entry reuses the slot being vacated.
    assign accept     = do_push && (!fifo_full || do_pop);
    assign head       = mem[rd_idx];
    assign new_entry  = {target, ptr, held_data};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            step     <= 8'd1;
            target   <= TGT_TILE;
            overflow <= 1'b0;
        end else begin
            if (commit) begin
                case (held_addr)
                    3'd0: ptr[7:0] <= held_data;
                    3'd1: begin
                        ptr[11:8] <= held_data[3:0];
                        target    <= target_t'(held_data[5:4]);
                    end
                    // The pointer advances whether or not the push is accepted.
                    3'd2: ptr  <= ptr + {4'h0, step};
                    3'd3: step <= held_data;
                    default: ;
                endcase
            end
            // Set and clear are never requested together: each CPU cycle
            // commits at most one register access.
            if (do_push && fifo_full && !do_pop) begin
                overflow <= 1'b1;
            end else if (do_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_idx <= wr_idx + AW'(1);
            end
            if (do_pop) begin
                rd_idx <= rd_idx + AW'(1);
            end
            case ({accept, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_idx] <= new_entry;
        end
    end

    assign fifo_level = count;

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tile_memory_write_enable      <= 1'b0;
            attribute_memory_write_enable <= 1'b0;
            color_memory_write_enable     <= 1'b0;
            memory_write_addr             <= '0;
            memory_write_data             <= '0;
        end else if (do_pop) begin
            tile_memory_write_enable      <= (head.target == TGT_TILE);
            attribute_memory_write_enable <= (head.target == TGT_ATTR);
            color_memory_write_enable     <= (head.target == TGT_COLOR);
            memory_write_addr             <= head.addr;
            memory_write_data             <= head.data;
        end else begin
            tile_memory_write_enable      <= 1'b0;
            attribute_memory_write_enable <= 1'b0;
            color_memory_write_enable     <= 1'b0;
        end
    end

endmodule
